// File: rtl/ips2l_pcie_dma_pkg.sv
// rtl/ips2l_pcie_dma_pkg.sv - shared TLP constants, FSM encoding and keep helper for the DMA MWr path
package ips2l_pcie_dma_pkg;

    localparam logic [2:0] FMT_3DW_DATA = 3'b010;
    localparam logic [2:0] FMT_4DW_DATA = 3'b011;
    localparam logic [4:0] TYPE_MEM     = 5'b00000;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_DATA  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } mwr_state_t;

    // Keep mask for the final data beat: a remainder of 0 means the beat is full.
    function automatic logic [3:0] keep_from_len(input logic [1:0] len);
        case (len)
            2'd1:    keep_from_len = 4'h1;
            2'd2:    keep_from_len = 4'h3;
            2'd3:    keep_from_len = 4'h7;
            default: keep_from_len = 4'hF;
        endcase
    endfunction

endpackage

// File: rtl/ips2l_pcie_axis_skid.sv
// rtl/ips2l_pcie_axis_skid.sv - 2-entry register skid with registered outputs
module ips2l_pcie_axis_skid #(
    parameter int W = 133
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] s_tdata,
    input  logic         s_tvalid,
    output logic         s_tready,
    output logic [W-1:0] m_tdata,
    output logic         m_tvalid,
    input  logic         m_tready
);

    // Entry 0 is always the head; entry 1 is only valid when entry 0 is.
    logic [W-1:0] ent0_q, ent1_q;
    logic         v0_q, v1_q;
    logic         push, pop;

    assign pop      = v0_q & m_tready;
    assign s_tready = ~v1_q | pop;
    assign push     = s_tvalid & s_tready;
    assign m_tdata  = ent0_q;
    assign m_tvalid = v0_q;

    // Shift entries on pop, append on push; simultaneous push and pop keeps occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent0_q <= '0;
            ent1_q <= '0;
            v0_q   <= 1'b0;
            v1_q   <= 1'b0;
        end else begin
            if (push && !pop) begin
                if (!v0_q) begin
                    ent0_q <= s_tdata;
                    v0_q   <= 1'b1;
                end else begin
                    ent1_q <= s_tdata;
                    v1_q   <= 1'b1;
                end
            end else if (pop && !push) begin
                ent0_q <= ent1_q;
                v0_q   <= v1_q;
                v1_q   <= 1'b0;
            end else if (pop && push) begin
                if (v1_q) begin
                    ent0_q <= ent1_q;
                    ent1_q <= s_tdata;
                end else begin
                    ent0_q <= s_tdata;
                end
            end
        end
    end

endmodule

// File: rtl/ips2l_pcie_dma_mwr_tx.sv
// rtl/ips2l_pcie_dma_mwr_tx.sv - forms one MWr TLP from a request and read-controller data beats
module ips2l_pcie_dma_mwr_tx
    import ips2l_pcie_dma_pkg::*;
#(
    parameter int RAM_ADDR_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_mwr_req,
    input  logic [9:0]                i_mwr_length,
    input  logic [63:0]               i_mwr_addr,
    input  logic [RAM_ADDR_WIDTH-1:0] i_ram_addr,
    input  logic [15:0]               i_req_id,
    output logic                      o_mwr_busy,
    output logic                      o_mwr_done,
    output logic                      o_rd_en,
    output logic [9:0]                o_rd_length,
    output logic [63:0]               o_rd_addr,
    output logic                      o_tlp_tx,
    output logic                      o_tx_hold,
    input  logic                      i_gen_tlp_start,
    input  logic [127:0]              i_rd_data,
    input  logic                      i_last_data,
    output logic                      o_axis_tvalid,
    output logic [127:0]              o_axis_tdata,
    output logic [3:0]                o_axis_tkeep,
    output logic                      o_axis_tlast,
    input  logic                      i_axis_tready
);

    localparam int SKID_W = 128 + 4 + 1;

    mwr_state_t                state_q, state_d;
    logic [9:0]                len_q;
    logic [63:0]               addr_q;
    logic [RAM_ADDR_WIDTH-1:0] ram_q;
    logic [15:0]               req_id_q;
    logic [7:0]                tag_q;

    logic              skid_in_ready, skid_in_valid, skid_out_valid;
    logic [SKID_W-1:0] skid_in_data, skid_out_data;
    logic              push_hdr, push_data, last_accept, is_4dw;
    logic [31:0]       dw0, dw1, dw2, dw3, addr_lo;
    logic [3:0]        hdr_keep, data_keep;

    // Header fields are built from the latched request so they stay stable across WAIT.
    assign is_4dw    = |addr_q[63:32];
    assign addr_lo   = addr_q[31:0] & 32'hFFFF_FFFC;
    assign dw0       = {(is_4dw ? FMT_4DW_DATA : FMT_3DW_DATA), TYPE_MEM, 14'd0, len_q};
    assign dw1       = {req_id_q, tag_q, ((len_q == 10'd1) ? 4'h0 : 4'hF), 4'hF};
    assign dw2       = is_4dw ? addr_q[63:32] : addr_lo;
    assign dw3       = is_4dw ? addr_lo : 32'd0;
    assign hdr_keep  = is_4dw ? 4'hF : 4'h7;
    assign data_keep = i_last_data ? keep_from_len(len_q[1:0]) : 4'hF;

    assign push_hdr      = (state_q == ST_WAIT) && i_gen_tlp_start && skid_in_ready;
    assign push_data     = (state_q == ST_DATA) && i_gen_tlp_start && skid_in_ready;
    assign skid_in_valid = push_hdr | push_data;
    assign skid_in_data  = (state_q == ST_WAIT) ? {dw3, dw2, dw1, dw0, hdr_keep, 1'b0}
                                                : {i_rd_data, data_keep, i_last_data};
    assign last_accept   = (state_q == ST_DRAIN) && o_axis_tvalid && i_axis_tready && o_axis_tlast;

    assign o_tx_hold     = ~skid_in_ready;
    assign o_rd_length   = len_q;
    assign o_rd_addr     = {{(64-RAM_ADDR_WIDTH){1'b0}}, ram_q};
    assign o_axis_tvalid = skid_out_valid;
    assign o_axis_tdata  = skid_out_data[SKID_W-1:5];
    assign o_axis_tkeep  = skid_out_data[4:1];
    assign o_axis_tlast  = skid_out_data[0];

    ips2l_pcie_axis_skid #(.W(SKID_W)) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_tdata  (skid_in_data),
        .s_tvalid (skid_in_valid),
        .s_tready (skid_in_ready),
        .m_tdata  (skid_out_data),
        .m_tvalid (skid_out_valid),
        .m_tready (i_axis_tready)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (i_mwr_req) state_d = ST_WAIT;
            ST_WAIT:  if (push_hdr) state_d = ST_DATA;
            ST_DATA:  if (push_data && i_last_data) state_d = ST_DRAIN;
            ST_DRAIN: if (last_accept) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State-decoded outputs; o_rd_en drops in DONE so the next request gives a clean rising edge.
    always_comb begin
        o_mwr_busy = (state_q != ST_IDLE);
        o_rd_en    = (state_q == ST_WAIT) || (state_q == ST_DATA) || (state_q == ST_DRAIN);
        o_tlp_tx   = (state_q == ST_DATA);
        o_mwr_done = (state_q == ST_DONE);
    end

    // Capture the request only when idle; later requests are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q    <= '0;
            addr_q   <= '0;
            ram_q    <= '0;
            req_id_q <= '0;
        end else if ((state_q == ST_IDLE) && i_mwr_req) begin
            len_q    <= i_mwr_length;
            addr_q   <= i_mwr_addr;
            ram_q    <= i_ram_addr;
            req_id_q <= i_req_id;
        end
    end

    // Tag advances once per completed TLP and wraps naturally at 8 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  tag_q <= '0;
        else if (state_q == ST_DONE) tag_q <= tag_q + 8'd1;
    end

endmodule

// File: tb/tb_ips2l_pcie_dma_mwr_tx.sv
// tb/tb_ips2l_pcie_dma_mwr_tx.sv - directed self-checking bench for the MWr TLP transmitter
module tb_ips2l_pcie_dma_mwr_tx;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         i_mwr_req = 1'b0;
    logic [9:0]   i_mwr_length = '0;
    logic [63:0]  i_mwr_addr = '0;
    logic [15:0]  i_ram_addr = '0;
    logic [15:0]  i_req_id = '0;
    logic         o_mwr_busy, o_mwr_done, o_rd_en, o_tlp_tx, o_tx_hold;
    logic [9:0]   o_rd_length;
    logic [63:0]  o_rd_addr;
    logic         i_gen_tlp_start = 1'b0;
    logic [127:0] i_rd_data = '0;
    logic         i_last_data = 1'b0;
    logic         o_axis_tvalid, o_axis_tlast;
    logic [127:0] o_axis_tdata;
    logic [3:0]   o_axis_tkeep;
    logic         i_axis_tready = 1'b1;

    always #5 clk = ~clk;

    ips2l_pcie_dma_mwr_tx #(.RAM_ADDR_WIDTH(16)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_mwr_req       (i_mwr_req),
        .i_mwr_length    (i_mwr_length),
        .i_mwr_addr      (i_mwr_addr),
        .i_ram_addr      (i_ram_addr),
        .i_req_id        (i_req_id),
        .o_mwr_busy      (o_mwr_busy),
        .o_mwr_done      (o_mwr_done),
        .o_rd_en         (o_rd_en),
        .o_rd_length     (o_rd_length),
        .o_rd_addr       (o_rd_addr),
        .o_tlp_tx        (o_tlp_tx),
        .o_tx_hold       (o_tx_hold),
        .i_gen_tlp_start (i_gen_tlp_start),
        .i_rd_data       (i_rd_data),
        .i_last_data     (i_last_data),
        .o_axis_tvalid   (o_axis_tvalid),
        .o_axis_tdata    (o_axis_tdata),
        .o_axis_tkeep    (o_axis_tkeep),
        .o_axis_tlast    (o_axis_tlast),
        .i_axis_tready   (i_axis_tready)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] pat(input int k, input logic [15:0] s);
        logic [7:0] kb;
        kb = k[7:0];
        for (int d = 0; d < 4; d++) pat[32*d +: 32] = {s, kb, 8'(d)};
    endfunction

    logic [127:0] q_data[$];
    logic [3:0]   q_keep[$];
    logic         q_last[$];
    int           cyc = 0, first_cyc = -1, last_cyc = -1, done_cyc = -1, done_cnt = 0;
    bit           pop_now = 1'b0, stall_prev = 1'b0;
    logic [132:0] out_prev = '0;
    int           rd_idx = 0, nbeats = 0;
    bit           src_en = 1'b0, rnd_ready = 1'b0, underrun = 1'b0;
    logic [15:0]  seed = '0;

    // Sample away from the active edge: record accepted beats, check stall stability.
    always @(negedge clk) begin
        cyc++;
        pop_now = rst_n && o_tlp_tx && i_gen_tlp_start && !o_tx_hold;
        if (rst_n) begin
            if (stall_prev) begin
                check_eq("tvalid_held", o_axis_tvalid, 1'b1);
                check_eq("beat_held", {o_axis_tdata, o_axis_tkeep, o_axis_tlast}, out_prev);
            end
            if (o_tx_hold) check_eq("hold_only_when_stalled", i_axis_tready, 1'b0);
            if (o_axis_tvalid && i_axis_tready) begin
                q_data.push_back(o_axis_tdata);
                q_keep.push_back(o_axis_tkeep);
                q_last.push_back(o_axis_tlast);
                if (first_cyc < 0) first_cyc = cyc;
                if (o_axis_tlast) last_cyc = cyc;
            end
            if (o_mwr_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
        stall_prev = rst_n && o_axis_tvalid && !i_axis_tready;
        out_prev   = {o_axis_tdata, o_axis_tkeep, o_axis_tlast};
    end

    // Read-controller model: advance on each pop, present the next beat after the edge.
    initial begin
        forever begin
            @(posedge clk);
            if (pop_now) rd_idx++;
            #1;
            i_rd_data       = pat(rd_idx, seed);
            i_last_data     = src_en && (rd_idx == nbeats - 1);
            i_gen_tlp_start = src_en && (!underrun || ($urandom_range(0, 3) != 0));
            i_axis_tready   = !rnd_ready || ($urandom_range(0, 1) == 1);
        end
    end

    task automatic start_req(input logic [9:0] len, input logic [63:0] addr, input logic [15:0] rid,
                             input logic [15:0] ram, input int nb, input bit rnd, input bit und);
        @(posedge clk); #1;
        q_data.delete(); q_keep.delete(); q_last.delete();
        first_cyc = -1; last_cyc = -1; done_cyc = -1;
        rd_idx = 0; nbeats = nb; seed = rid ^ {6'd0, len} ^ ram;
        rnd_ready = rnd; underrun = und;
        i_mwr_req = 1'b1; i_mwr_length = len; i_mwr_addr = addr; i_req_id = rid; i_ram_addr = ram;
        @(posedge clk); #1;
        i_mwr_req = 1'b0;
        src_en = 1'b1;
    endtask

    task automatic run_mwr(input string name, input logic [9:0] len, input logic [63:0] addr,
                           input logic [15:0] rid, input logic [15:0] ram, input int nb,
                           input logic [127:0] hdr, input logic [3:0] hkeep, input logic [3:0] lkeep,
                           input bit rnd, input bit und);
        int t;
        int errs;
        int dc0;
        dc0 = done_cnt;
        check_eq({name, "_rd_en_low_before"}, o_rd_en, 1'b0);
        start_req(len, addr, rid, ram, nb, rnd, und);
        check_eq({name, "_busy"}, o_mwr_busy, 1'b1);
        check_eq({name, "_rd_en"}, o_rd_en, 1'b1);
        check_eq({name, "_rd_addr"}, o_rd_addr, {48'd0, ram});
        // A request while busy must not disturb the latched length.
        i_mwr_req = 1'b1; i_mwr_length = ~len;
        @(posedge clk); #1;
        i_mwr_req = 1'b0;
        check_eq({name, "_rd_length"}, o_rd_length, len);
        t = 0;
        while (done_cnt == dc0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check_eq({name, "_done_once"}, done_cnt - dc0, 1);
        check_eq({name, "_rd_en_low_in_done"}, o_rd_en, 1'b0);
        src_en = 1'b0;
        check_eq({name, "_beats"}, q_data.size(), nb + 1);
        if (q_data.size() > 0) begin
            check_eq({name, "_hdr"}, q_data[0], hdr);
            check_eq({name, "_hdr_keep"}, q_keep[0], hkeep);
            check_eq({name, "_hdr_last"}, q_last[0], 1'b0);
        end
        errs = 0;
        for (int i = 1; i < q_data.size(); i++) begin
            if (q_data[i] !== pat(i - 1, seed)) errs++;
            if (q_keep[i] !== ((i == nb) ? lkeep : 4'hF)) errs++;
            if (q_last[i] !== (i == nb)) errs++;
        end
        check_eq({name, "_data_errs"}, errs, 0);
        check_eq({name, "_done_latency"}, done_cyc - last_cyc, 1);
        if (!rnd && !und) check_eq({name, "_throughput"}, last_cyc - first_cyc, nb);
        @(negedge clk);
        check_eq({name, "_done_pulse_end"}, o_mwr_done, 1'b0);
        check_eq({name, "_busy_clear"}, o_mwr_busy, 1'b0);
    endtask

    function automatic logic [255:0] all_outs();
        all_outs = {43'd0, o_mwr_busy, o_mwr_done, o_rd_en, o_rd_length, o_rd_addr, o_tlp_tx,
                    o_tx_hold, o_axis_tvalid, o_axis_tdata, o_axis_tkeep, o_axis_tlast};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int dc0;
        int qs;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_outputs", all_outs(), 256'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        run_mwr("t1_len8", 10'd8, 64'h0000_0000_1000_0040, 16'h0100, 16'h0123, 2,
                128'h00000000_10000040_010000FF_40000008, 4'h7, 4'hF, 1'b0, 1'b0);
        run_mwr("t2_len5_4dw", 10'd5, 64'h0000_0001_0000_0000, 16'h0100, 16'h0200, 2,
                128'h00000000_00000001_010001FF_60000005, 4'hF, 4'h1, 1'b0, 1'b0);
        run_mwr("t3_len1", 10'd1, 64'h0000_0000_0000_0800, 16'h0100, 16'h0300, 1,
                128'h00000000_00000800_0100020F_40000001, 4'h7, 4'h1, 1'b0, 1'b0);
        run_mwr("t4_len1024", 10'd0, 64'h0000_0000_0000_2000, 16'h0100, 16'h0400, 256,
                128'h00000000_00002000_010003FF_40000000, 4'h7, 4'hF, 1'b0, 1'b0);
        run_mwr("t5_len64_rand", 10'd64, 64'h0000_0000_0000_3000, 16'hABCD, 16'h0500, 16,
                128'h00000000_00003000_ABCD04FF_40000040, 4'h7, 4'hF, 1'b1, 1'b1);

        // Reset in the middle of a long transfer.
        dc0 = done_cnt;
        start_req(10'd32, 64'h0000_0000_0000_0100, 16'h0100, 16'h0600, 8, 1'b0, 1'b0);
        t = 0;
        while (q_data.size() < 4 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check_eq("t6_reached_beat3", q_data.size() >= 4, 1'b1);
        check_eq("t6_in_data", o_tlp_tx, 1'b1);
        rst_n = 1'b0;
        src_en = 1'b0;
        #1;
        check_eq("t6_outputs_zero", all_outs(), 256'd0);
        qs = q_data.size();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check_eq("t6_no_beats_after_reset", q_data.size(), qs);
        check_eq("t6_no_done_after_reset", done_cnt - dc0, 0);
        check_eq("t6_idle_after_reset", o_mwr_busy, 1'b0);

        run_mwr("t6_after_reset", 10'd2, 64'h0000_0000_0000_0040, 16'h0100, 16'h0010, 1,
                128'h00000000_00000040_010000FF_40000002, 4'h7, 4'h3, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ips2l_pcie_dma_mwr_tx.md
Name: ips2l_pcie_dma_mwr_tx

Overview:
Downstream consumer of the DMA read controller. Accepts one memory-write request, starts the read controller, and forms a PCIe MWr TLP. It emits one header beat, then streams the controller's aligned 128-bit data beats onto the PCIe core's AXI-Stream TX port. An internal 2-entry skid buffer decouples core backpressure from the read-controller FIFO pop.

Parameters:
RAM_ADDR_WIDTH, 16, width of i_ram_addr (byte address into BAR RAM).

Ports:
clk  in  1  user clock (gen1 62.5 MHz, gen2 125 MHz)
rst_n  in  1  reset
i_mwr_req  in  1  request pulse; sampled only in IDLE
i_mwr_length  in  10  payload DW; 0 means 1024
i_mwr_addr  in  64  host byte address, DW aligned
i_ram_addr  in  RAM_ADDR_WIDTH  BAR RAM source byte address
i_req_id  in  16  requester ID (bus/dev/func)
o_mwr_busy  out  1  high from request accept until DONE exits
o_mwr_done  out  1  one-cycle pulse when last beat accepted by core
o_rd_en  out  1  level to read controller; rising edge starts read
o_rd_length  out  10  latched i_mwr_length
o_rd_addr  out  64  zero-extended latched i_ram_addr
o_tlp_tx  out  1  high in DATA state
o_tx_hold  out  1  ~skid_in_ready
i_gen_tlp_start  in  1  read FIFO data valid
i_rd_data  in  128  read FIFO data, DW0 in [31:0]
i_last_data  in  1  high with pop of final beat
o_axis_tvalid  out  1  core TX valid
o_axis_tdata  out  128  core TX data
o_axis_tkeep  out  4  per-DW keep
o_axis_tlast  out  1  last beat of TLP
i_axis_tready  in  1  core TX ready

Behaviour:
- Reset is asynchronous, active-low. While rst_n=0, all outputs are 0, FSM=IDLE, tag=0, skid empty. Reset mid-transfer aborts: no further beats and no done pulse.
- FSM states and transitions:
  - IDLE: on i_mwr_req, latch length, addr, ram_addr and req_id; set busy and o_rd_en; go to WAIT.
  - WAIT: when i_gen_tlp_start=1 and skid_in_ready=1, push the header beat; go to DATA.
  - DATA: o_tlp_tx=1. The read controller pops when i_gen_tlp_start && ~o_tx_hold; each pop pushes i_rd_data into the skid. On a pop with i_last_data=1, mark that entry last and go to DRAIN.
  - DRAIN: o_tlp_tx=0; wait for the last-marked beat to be accepted (tvalid && tready); then pulse o_mwr_done, clear o_rd_en, go to DONE.
  - DONE: one cycle with o_rd_en=0, which guarantees the next rising edge is seen; busy clears; return to IDLE.
- Header format. Header selection: use 4DW when addr[63:32]≠0, else 3DW.
  - DW0: Fmt = 3'b011 (4DW) or 3'b010 (3DW); Type = 5'b00000; TC, TD, EP, Attr, AT = 0; Length = latched length.
  - DW1: {req_id, tag, LastBE, FirstBE}. FirstBE = 4'hF. LastBE = 4'h0 if length=1, else 4'hF.
  - 4DW: DW2 = addr[63:32], DW3 = {addr[31:2], 2'b00}.
  - 3DW: DW2 = {addr[31:2], 2'b00}, DW3 = 0.
  - Header beat: tkeep = 4'hF (4DW) or 4'h7 (3DW); tlast = 0.
- Data beats: tkeep = 4'hF, except the last beat, where r = length mod 4 gives tkeep 4'h1/4'h3/4'h7 for r = 1/2/3 and 4'hF for r = 0. The last beat has tlast = 1. Beat count = ceil(len/4); length 0 → 256 beats.
- Tag: increments by 1 on each o_mwr_done and wraps 255 → 0.
- Skid (2 entries): o_axis_* come straight from registers, with no combinational path from i_axis_tready. skid_in_ready = entries < 2 after accounting for the same-cycle pop. Simultaneous push and pop keeps the count unchanged. The FIFO pop is never issued when the skid is full.
- Latency: header tvalid appears 1 cycle after the header push. Sustained throughput is 1 beat/cycle while tready=1.
- i_mwr_req outside IDLE is ignored.
- i_gen_tlp_start dropping mid-DATA (FIFO underrun) is legal: no push occurs; wait.
- The caller guarantees length ≤ negotiated max payload; no TLP splitting is performed.

Decomposition:
- Shared package ips2l_pcie_dma_pkg: FMT_3DW_DATA=3'b010, FMT_4DW_DATA=3'b011, TYPE_MEM=5'b00000, FSM state encodings (IDLE, WAIT, DATA, DRAIN, DONE), function keep_from_len(len[1:0]).
- One sub-module: ips2l_pcie_axis_skid (2-entry register skid, width 128+4+1, valid/ready both sides).

Test Plan:
1. len=8, addr=0x0000_0000_1000_0040, req_id=0x0100, tready=1 → 3 beats. Header DW0=0x4000_0008, DW1=0x0100_00FF, DW2=0x1000_0040, keep 7. Two data beats with keep F; tlast on beat 3; done 1 cycle later; tag becomes 1.
2. len=5, addr=0x0000_0001_0000_0000 → DW0=0x6000_0005, DW2=0x0000_0001, DW3=0x0. Data beats keep F then 1; tlast on 3rd beat.
3. len=1 → DW1 low byte 0x0F; one data beat, keep 1, tlast=1.
4. len=0 (1024 DW) → DW0 Length field 0; exactly 256 data beats, tlast only on the 256th.
5. len=64 with random tready (50%) → data sequence matches RAM, no drop or duplicate. o_tx_hold=1 whenever the skid is full; tvalid/tdata stable while tready=0.
6. rst_n asserted in DATA at beat 3 → all outputs 0 next edge; tag=0. A new request after release completes normally with a fresh o_rd_en rising edge.
